// File: rtl/pciexp_pkg.sv
// Shared symbol constants and SKP scheduler state encoding for the PCIe Gen1 TX symbol stage.
package pciexp_pkg;

  localparam logic [7:0]  K_COM     = 8'hBC;
  localparam logic [7:0]  K_SKP     = 8'h1C;
  localparam logic [15:0] LFSR_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    SKP1   = 2'd1,
    SKP2   = 2'd2,
    SKP3   = 2'd3
  } skp_state_t;

endpackage

// File: rtl/pciexp_lfsr8.sv
// Eight serial shifts of the X^16+X^5+X^4+X^3+1 scrambler LFSR collapsed into one cycle.
// Purely combinational; key bit n is lfsr[15] as seen just before shift n.
module pciexp_lfsr8
  import pciexp_pkg::*;
(
  input  logic [15:0] i_lfsr_in,
  output logic [15:0] o_lfsr_out,
  output logic [7:0]  o_key
);

  always_comb begin
    logic [15:0] w_shift;
    w_shift = i_lfsr_in;
    o_key   = 8'h00;
    for (int n = 0; n < 8; n++) begin
      o_key[n] = w_shift[15];
      w_shift  = {w_shift[14:5], w_shift[4] ^ w_shift[15], w_shift[3] ^ w_shift[15],
                  w_shift[2] ^ w_shift[15], w_shift[1:0], w_shift[15]};
    end
    o_lfsr_out = w_shift;
  end

endmodule

// File: rtl/pciexp_tx_scramble.sv
// PCIe Gen1 TX symbol stage: scrambles link-layer bytes and, with PCIEXP_SKP_INSERT_EN defined,
// inserts COM+3xSKP ordered sets at packet boundaries every SKP_INTERVAL symbols. One-cycle latency.
module pciexp_tx_scramble
  import pciexp_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL = 1180
) (
  input  logic       PCLK250,
  input  logic       Reset_P2,
  input  logic [7:0] TxData_P1,
  input  logic       TxKCode_P1,
  input  logic       TxValid_P1,
  input  logic       TxPktEnd_P1,
  input  logic       ScrDisable_P1,
  output logic       TxReady_P1,
  output logic [7:0] DataOut_P2,
  output logic       KCodeOut_P2,
  output logic       UseNegDisp_P2
);

  logic [15:0] r_lfsr, w_lfsr_nxt, w_lfsr_adv;
  logic [7:0]  w_key, r_dat, w_dat_nxt;
  logic        r_k, w_k_nxt;
  logic        r_neg_disp, r_neg_arm;
  logic        w_ready, w_accept;

  pciexp_lfsr8 u_lfsr8 (
    .i_lfsr_in  (r_lfsr),
    .o_lfsr_out (w_lfsr_adv),
    .o_key      (w_key)
  );

`ifdef PCIEXP_SKP_INSERT_EN
  localparam logic [10:0] SKP_LIM = 11'(SKP_INTERVAL);

  skp_state_t  r_state, w_state_nxt;
  logic [10:0] r_cnt, w_cnt_nxt;
  logic        r_skp_pend, w_skp_pend_nxt;
  logic        r_at_bnd, w_at_bnd_nxt;
  logic        w_insert;

  assign w_insert = (r_state == NORMAL) & r_skp_pend & r_at_bnd;
  assign w_ready  = (r_state == NORMAL) & ~(r_skp_pend & r_at_bnd);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (SKP_INTERVAL != 0) | TxPktEnd_P1;
  assign w_ready      = 1'b1;
`endif

  assign TxReady_P1 = ~Reset_P2 & w_ready;
  assign w_accept   = TxValid_P1 & w_ready;

  // Symbol selection and LFSR bookkeeping; an empty slot carries a scrambled logical idle.
  always_comb begin
    w_dat_nxt  = ScrDisable_P1 ? 8'h00 : w_key;
    w_k_nxt    = 1'b0;
    w_lfsr_nxt = w_lfsr_adv;
    if (w_accept) begin
      if (TxKCode_P1) begin
        w_dat_nxt = TxData_P1;
        w_k_nxt   = 1'b1;
        if (TxData_P1 == K_COM) begin
          w_lfsr_nxt = LFSR_SEED;
        end else if (TxData_P1 == K_SKP) begin
          w_lfsr_nxt = r_lfsr;
        end
      end else begin
        w_dat_nxt = TxData_P1 ^ (ScrDisable_P1 ? 8'h00 : w_key);
      end
    end
`ifdef PCIEXP_SKP_INSERT_EN
    if (w_insert) begin
      w_dat_nxt  = K_COM;
      w_k_nxt    = 1'b1;
      w_lfsr_nxt = LFSR_SEED;
    end else if (r_state != NORMAL) begin
      w_dat_nxt  = K_SKP;
      w_k_nxt    = 1'b1;
      w_lfsr_nxt = r_lfsr;
    end
`endif
  end

`ifdef PCIEXP_SKP_INSERT_EN
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = (r_cnt == SKP_LIM) ? r_cnt : r_cnt + 11'd1;
    w_skp_pend_nxt = r_skp_pend | (w_cnt_nxt == SKP_LIM);
    w_at_bnd_nxt   = r_at_bnd;
    case (r_state)
      NORMAL: begin
        if (w_insert) begin
          w_state_nxt    = SKP1;
          w_cnt_nxt      = 11'd0;
          w_skp_pend_nxt = 1'b0;
          w_at_bnd_nxt   = 1'b1;
        end else if (w_accept) begin
          w_at_bnd_nxt = TxPktEnd_P1;
        end else begin
          w_at_bnd_nxt = 1'b1;
        end
      end
      SKP1: begin
        w_state_nxt  = SKP2;
        w_at_bnd_nxt = 1'b1;
      end
      SKP2: begin
        w_state_nxt  = SKP3;
        w_at_bnd_nxt = 1'b1;
      end
      default: begin
        w_state_nxt  = NORMAL;
        w_at_bnd_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge PCLK250) begin
    if (Reset_P2) begin
      r_state    <= NORMAL;
      r_cnt      <= 11'd0;
      r_skp_pend <= 1'b0;
      r_at_bnd   <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_skp_pend <= w_skp_pend_nxt;
      r_at_bnd   <= w_at_bnd_nxt;
    end
  end
`endif

  // Negative disparity is forced on the reset value and the first symbol after release.
  always_ff @(posedge PCLK250) begin
    if (Reset_P2) begin
      r_lfsr     <= LFSR_SEED;
      r_dat      <= 8'h00;
      r_k        <= 1'b0;
      r_neg_disp <= 1'b1;
      r_neg_arm  <= 1'b1;
    end else begin
      r_lfsr     <= w_lfsr_nxt;
      r_dat      <= w_dat_nxt;
      r_k        <= w_k_nxt;
      r_neg_disp <= r_neg_arm;
      r_neg_arm  <= 1'b0;
    end
  end

  assign DataOut_P2    = r_dat;
  assign KCodeOut_P2   = r_k;
  assign UseNegDisp_P2 = r_neg_disp;

endmodule

// File: tb/tb_pciexp_tx_scramble.sv
// Self-checking bench for pciexp_tx_scramble with SKP_INTERVAL=16; SKP scenarios compile only
// when PCIEXP_SKP_INSERT_EN is defined, matching the design build.
module tb_pciexp_tx_scramble;

  localparam int INTERVAL = 16;
`ifdef PCIEXP_SKP_INSERT_EN
  localparam bit SKP_ON = 1'b1;
`else
  localparam bit SKP_ON = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic [7:0] tx_dat  = 8'h00;
  logic       tx_k    = 1'b0;
  logic       tx_vld  = 1'b0;
  logic       tx_end  = 1'b0;
  logic       scr_dis = 1'b0;
  logic       tx_rdy;
  logic [7:0] dout;
  logic       kout;
  logic       negd;

  always #5 clk = ~clk;

  pciexp_tx_scramble #(.SKP_INTERVAL(INTERVAL)) dut (
    .PCLK250       (clk),
    .Reset_P2      (rst),
    .TxData_P1     (tx_dat),
    .TxKCode_P1    (tx_k),
    .TxValid_P1    (tx_vld),
    .TxPktEnd_P1   (tx_end),
    .ScrDisable_P1 (scr_dis),
    .TxReady_P1    (tx_rdy),
    .DataOut_P2    (dout),
    .KCodeOut_P2   (kout),
    .UseNegDisp_P2 (negd)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: polynomial-form LFSR plus a symbol-level view of the SKP schedule.
  logic [15:0] m_lfsr;
  int          m_since;
  bit          m_bnd;
  bit          m_first;
  logic [7:0]  m_forced[$];

  function automatic logic [23:0] advance(input logic [15:0] l);
    logic [7:0] key;
    key = 8'h00;
    for (int n = 0; n < 8; n++) begin
      key[n] = l[15];
      l = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
    end
    return {key, l};
  endfunction

  task automatic model_reset();
    m_lfsr  = 16'hFFFF;
    m_since = 0;
    m_bnd   = 1'b1;
    m_first = 1'b1;
    m_forced.delete();
  endtask

  task automatic model_step(input bit vld, input logic [7:0] d, input bit k, input bit pend,
                            input bit dis, output bit e_rdy, output logic [7:0] e_dat,
                            output bit e_k, output bit e_neg);
    logic [23:0] a;
    a       = advance(m_lfsr);
    e_neg   = m_first;
    m_first = 1'b0;
    e_rdy   = (m_forced.size() == 0) && !(SKP_ON && m_since >= INTERVAL && m_bnd);
    e_k     = 1'b0;
    e_dat   = 8'h00;
    if (m_forced.size() > 0) begin
      e_dat = m_forced.pop_front();
      e_k   = 1'b1;
      m_bnd = 1'b1;
      m_since++;
    end else if (!e_rdy) begin
      e_dat   = 8'hBC;
      e_k     = 1'b1;
      m_lfsr  = 16'hFFFF;
      m_since = 0;
      m_bnd   = 1'b1;
      repeat (3) m_forced.push_back(8'h1C);
    end else begin
      m_since++;
      if (vld) begin
        m_bnd = pend;
        if (k) begin
          e_dat = d;
          e_k   = 1'b1;
          if (d == 8'hBC) m_lfsr = 16'hFFFF;
          else if (d != 8'h1C) m_lfsr = a[15:0];
        end else begin
          e_dat  = dis ? d : d ^ a[23:16];
          m_lfsr = a[15:0];
        end
      end else begin
        m_bnd  = 1'b1;
        e_dat  = dis ? 8'h00 : a[23:16];
        m_lfsr = a[15:0];
      end
    end
  endtask

  // Drives one cycle, samples TxReady before the edge and leaves time at edge+1.
  task automatic cyc(input bit vld, input logic [7:0] d, input bit k, input bit pend,
                     input bit dis, output bit e_rdy, output logic [7:0] e_dat,
                     output bit e_k, output bit e_neg, output bit g_rdy);
    tx_vld = vld; tx_dat = d; tx_k = k; tx_end = pend; scr_dis = dis;
    #1;
    g_rdy = tx_rdy;
    model_step(vld, d, k, pend, dis, e_rdy, e_dat, e_k, e_neg);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tx_vld = 1'b0; tx_k = 1'b0; tx_end = 1'b0; scr_dis = 1'b0; tx_dat = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_vld = 1'b1; tx_dat = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", dout); end
    n_checks++; if (kout !== 1'b0) begin n_fail++; $display("FAIL reset_k: got %b want 0", kout); end
    n_checks++; if (negd !== 1'b1) begin n_fail++; $display("FAIL reset_negdisp: got %b want 1", negd); end
    n_checks++; if (tx_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", tx_rdy); end
    rst = 1'b0; tx_vld = 1'b0;
    model_reset();
    #1;
    n_checks++; if (tx_rdy !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", tx_rdy); end
  endtask

  // Runs a short directed sequence against constant expectations.
  task automatic run_table(input string name, input int len, input logic [7:0] sd[4],
                           input bit sk[4], input bit sdis[4], input logic [7:0] wd[4],
                           input bit wk[4], input bit wneg[4]);
    bit er, ek, en, gr;
    logic [7:0] ed;
    do_reset();
    for (int i = 0; i < len; i++) begin
      cyc(1'b1, sd[i], sk[i], 1'b0, sdis[i], er, ed, ek, en, gr);
      n_checks++;
      if (dout !== wd[i] || kout !== wk[i]) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %h/K%b want %h/K%b", name, i, dout, kout, wd[i], wk[i]);
      end
      n_checks++;
      if (negd !== wneg[i]) begin
        n_fail++; $display("FAIL %s_negdisp[%0d]: got %b want %b", name, i, negd, wneg[i]);
      end
      n_checks++;
      if (gr !== 1'b1) begin n_fail++; $display("FAIL %s_ready[%0d]: got %b want 1", name, i, gr); end
    end
  endtask

  task automatic test_basic();
    run_table("basic", 3, '{8'hBC, 8'h00, 8'h00, 8'h00}, '{1, 0, 0, 0}, '{0, 0, 0, 0},
              '{8'hBC, 8'hFF, 8'h17, 8'h00}, '{1, 0, 0, 0}, '{1, 0, 0, 0});
  endtask

  task automatic test_skp_holds_lfsr();
    run_table("skp_hold", 4, '{8'hBC, 8'h00, 8'h1C, 8'h00}, '{1, 0, 1, 0}, '{0, 0, 0, 0},
              '{8'hBC, 8'hFF, 8'h1C, 8'h17}, '{1, 0, 1, 0}, '{1, 0, 0, 0});
  endtask

  task automatic test_scr_disable();
    run_table("scr_dis", 3, '{8'hBC, 8'hA5, 8'h00, 8'h00}, '{1, 0, 0, 0}, '{0, 1, 0, 0},
              '{8'hBC, 8'hA5, 8'h17, 8'h00}, '{1, 0, 0, 0}, '{1, 0, 0, 0});
  endtask

`ifdef PCIEXP_SKP_INSERT_EN
  task automatic test_skp_idle();
    bit er, ek, en, gr, ins;
    logic [7:0] ed, want;
    do_reset();
    for (int i = 0; i < 37; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, er, ed, ek, en, gr);
      ins  = (i >= 16 && i <= 19) || (i >= 33 && i <= 36);
      want = (i == 16 || i == 33) ? 8'hBC : (ins ? 8'h1C : ed);
      n_checks++;
      if (gr !== !ins) begin n_fail++; $display("FAIL skp_idle_ready[%0d]: got %b want %b", i, gr, !ins); end
      n_checks++;
      if (dout !== want || kout !== ins) begin
        n_fail++; $display("FAIL skp_idle_sym[%0d]: got %h/K%b want %h/K%b", i, dout, kout, want, ins);
      end
    end
  endtask

  task automatic test_skp_packet();
    bit er, ek, en, gr;
    logic [7:0] ed, d;
    do_reset();
    for (int i = 0; i < 41; i++) begin
      d = 8'($urandom);
      cyc(i < 40, d, 1'b0, i == 39, 1'b0, er, ed, ek, en, gr);
      n_checks++;
      if (gr !== (i < 40)) begin n_fail++; $display("FAIL pkt_ready[%0d]: got %b want %b", i, gr, i < 40); end
      n_checks++;
      if (dout !== ((i == 40) ? 8'hBC : ed) || kout !== (i == 40)) begin
        n_fail++;
        $display("FAIL pkt_sym[%0d]: got %h/K%b want %h/K%b", i, dout, kout, (i == 40) ? 8'hBC : ed, i == 40);
      end
    end
  endtask

  task automatic test_reset_mid_skp();
    bit er, ek, en, gr;
    logic [7:0] ed;
    do_reset();
    for (int i = 0; i < 18; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, er, ed, ek, en, gr);
    n_checks++;
    if (dout !== 8'h1C || kout !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_skp: got %h/K%b want 1c/K1", dout, kout);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (dout !== 8'h00 || kout !== 1'b0 || tx_rdy !== 1'b0) begin
      n_fail++; $display("FAIL mid_skp_reset: got %h/K%b rdy%b want 00/K0 rdy0", dout, kout, tx_rdy);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 17; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, er, ed, ek, en, gr);
      n_checks++;
      if (gr !== (i < 16)) begin n_fail++; $display("FAIL after_reset_ready[%0d]: got %b want %b", i, gr, i < 16); end
      n_checks++;
      if (dout !== ((i == 16) ? 8'hBC : ed) || kout !== (i == 16)) begin
        n_fail++; $display("FAIL after_reset_sym[%0d]: got %h/K%b", i, dout, kout);
      end
    end
  endtask
`endif

  task automatic test_random();
    bit er, ek, en, gr, p_vld, p_k, p_end, p_dis;
    logic [7:0] ed, p_d;
    p_vld = 1'b0; p_k = 1'b0; p_end = 1'b0; p_d = 8'h00;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!p_vld && $urandom_range(0, 9) < 7) begin
        p_vld = 1'b1;
        p_k   = ($urandom_range(0, 9) == 0);
        if (p_k) begin
          case ($urandom_range(0, 3))
            0: p_d = 8'hBC;
            1: p_d = 8'h1C;
            2: p_d = 8'hFB;
            default: p_d = 8'hFD;
          endcase
        end else begin
          p_d = 8'($urandom);
        end
        p_end = ($urandom_range(0, 19) < 3);
      end
      p_dis = ($urandom_range(0, 15) == 0);
      cyc(p_vld, p_d, p_k, p_end, p_dis, er, ed, ek, en, gr);
      if (p_vld && gr) p_vld = 1'b0;
      n_checks++;
      if (gr !== er) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", i, gr, er); end
      n_checks++;
      if (dout !== ed || kout !== ek) begin
        n_fail++; $display("FAIL rand_sym[%0d]: got %h/K%b want %h/K%b", i, dout, kout, ed, ek);
      end
      n_checks++;
      if (negd !== en) begin n_fail++; $display("FAIL rand_negdisp[%0d]: got %b want %b", i, negd, en); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skp_holds_lfsr();
    test_scr_disable();
`ifdef PCIEXP_SKP_INSERT_EN
    test_skp_idle();
    test_skp_packet();
    test_reset_mid_skp();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
